// File: rtl/front_panel_switches.sv
// Front panel input block: four direction buttons drive the switch cursor, the address
// switch latches and the control switch pulses. Optional macro FRONT_PANEL_AUTOREPEAT_EN.
module front_panel_switches #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [15:0] ADDR_SW_INIT    = 16'h0000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
  parameter logic [23:0] REPEAT_RATE     = 24'd1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        left,
  input  logic        right,
  input  logic        up,
  input  logic        down,
  output logic [4:0]  curr_sw,
  output logic [15:0] addr_sw,
  output logic [8:0]  ctl_up,
  output logic [8:0]  ctl_down
);

  // Button bit order everywhere: {down, up, right, left}
  logic [3:0]  sync1_r, sync2_r, deb_r, deb_d_r;
  logic [15:0] cnt_r [4];
  logic [3:0]  ev_s;
  logic [1:0]  rep_ev_s;
  logic [4:0]  curr_nxt_s;
  logic [15:0] addr_nxt_s;
  logic [8:0]  up_nxt_s, down_nxt_s;
  logic [8:0]  ctl_sel_s;

  // Two-stage synchroniser and per-button debounce counters
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
      deb_r   <= 4'b0000;
      deb_d_r <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= 16'd0;
      end
    end else begin
      sync1_r <= {down, up, right, left};
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          cnt_r[i] <= 16'd0;
        end else if (cnt_r[i] == DEBOUNCE_CYCLES - 16'd1) begin
          deb_r[i] <= ~deb_r[i];
          cnt_r[i] <= 16'd0;
        end else begin
          cnt_r[i] <= cnt_r[i] + 16'd1;
        end
      end
    end
  end

`ifdef FRONT_PANEL_AUTOREPEAT_EN
  logic [23:0] rep_cnt_r [2];
  logic [1:0]  rep_run_r, rep_ev_r;

  // Left/right auto-repeat: first event after REPEAT_DELAY, then every REPEAT_RATE
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_run_r <= 2'b00;
      rep_ev_r  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        rep_cnt_r[i] <= 24'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        rep_ev_r[i] <= 1'b0;
        if (!deb_r[i]) begin
          rep_cnt_r[i] <= 24'd0;
          rep_run_r[i] <= 1'b0;
        end else if (rep_cnt_r[i] == (rep_run_r[i] ? REPEAT_RATE : REPEAT_DELAY) - 24'd1) begin
          rep_cnt_r[i] <= 24'd0;
          rep_run_r[i] <= 1'b1;
          rep_ev_r[i]  <= 1'b1;
        end else begin
          rep_cnt_r[i] <= rep_cnt_r[i] + 24'd1;
        end
      end
    end
  end

  assign rep_ev_s = rep_ev_r;
`else
  logic unused_repeat_s;
  assign unused_repeat_s = ^{REPEAT_DELAY, REPEAT_RATE};
  assign rep_ev_s = 2'b00;
`endif

  // Event decode and next panel state; up/down act on the pre-move cursor
  always_comb begin
    ev_s       = (deb_r & ~deb_d_r) | {2'b00, rep_ev_s};
    curr_nxt_s = curr_sw;
    addr_nxt_s = addr_sw;
    up_nxt_s   = 9'h000;
    down_nxt_s = 9'h000;
    ctl_sel_s  = 9'h001 << curr_sw[3:0];

    if (ev_s[0] && !ev_s[1]) begin
      if (curr_sw > 5'd24) begin
        curr_nxt_s = 5'd0;
      end else if (curr_sw == 5'd0) begin
        curr_nxt_s = 5'd24;
      end else begin
        curr_nxt_s = curr_sw - 5'd1;
      end
    end else if (ev_s[1] && !ev_s[0]) begin
      if (curr_sw >= 5'd24) begin
        curr_nxt_s = 5'd0;
      end else begin
        curr_nxt_s = curr_sw + 5'd1;
      end
    end else begin
      curr_nxt_s = curr_sw;
    end

    if ((ev_s[2] ^ ev_s[3]) && (curr_sw <= 5'd24)) begin
      if (curr_sw < 5'd16) begin
        addr_nxt_s[curr_sw[3:0]] = ev_s[2];
      end else if (ev_s[2]) begin
        up_nxt_s = ctl_sel_s;
      end else begin
        down_nxt_s = ctl_sel_s;
      end
    end else begin
      addr_nxt_s = addr_sw;
    end
  end

  // Registered panel outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      curr_sw  <= 5'd0;
      addr_sw  <= ADDR_SW_INIT;
      ctl_up   <= 9'h000;
      ctl_down <= 9'h000;
    end else begin
      curr_sw  <= curr_nxt_s;
      addr_sw  <= addr_nxt_s;
      ctl_up   <= up_nxt_s;
      ctl_down <= down_nxt_s;
    end
  end

endmodule
